fetch_pc_unit: RTL

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit.sv | 82 ++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC register with stall-deferred redirects and saturating statistics
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i2i_stall,
  input  logic                   i2i_flush,
  input  logic                   load_pc_we,
  input  logic [31:0]            load_pc_new_pc,
  output logic [31:0]            fetch_pc,
  output logic                   fetch_valid,
  output logic                   redirect_pending,
  output logic                   misalign_seen,
  output logic [COUNT_WIDTH-1:0] fetch_count,
  output logic [COUNT_WIDTH-1:0] redirect_count,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [31:0] pc_q;
  logic [31:0] pend_pc;
  logic        pend_valid;
  logic        out_of_reset;
  logic [31:0] target;
  logic        unused_flush;

  // The hazard controller never asserts flush; redirects arrive via load_pc.
  assign unused_flush = i2i_flush;

  assign target           = {load_pc_new_pc[31:2], 2'b00};
  assign fetch_pc         = pc_q;
  assign fetch_valid      = out_of_reset & ~pend_valid;
  assign redirect_pending = pend_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      pend_valid     <= 1'b0;
      pend_pc        <= 32'h0;
      out_of_reset   <= 1'b0;
      misalign_seen  <= 1'b0;
      fetch_count    <= '0;
      redirect_count <= '0;
      stall_count    <= '0;
    end else begin
      out_of_reset <= 1'b1;
      if (load_pc_we && (load_pc_new_pc[1:0] != 2'b00)) begin
        misalign_seen <= 1'b1;
      end
      if (!i2i_stall) begin
        // A live redirect beats a latched one; the latched one is dropped.
        if (load_pc_we) begin
          pc_q <= target;
        end else if (pend_valid) begin
          pc_q <= pend_pc;
        end else begin
          pc_q <= pc_q + 32'd4;
        end
        pend_valid <= 1'b0;
        if (fetch_valid && fetch_count != CNT_MAX) begin
          fetch_count <= fetch_count + CNT_ONE;
        end
        if ((load_pc_we || pend_valid) && redirect_count != CNT_MAX) begin
          redirect_count <= redirect_count + CNT_ONE;
        end
      end else begin
        if (load_pc_we) begin
          pend_valid <= 1'b1;
          pend_pc    <= target;
        end
        if (out_of_reset && stall_count != CNT_MAX) begin
          stall_count <= stall_count + CNT_ONE;
        end
      end
    end
  end

endmodule
